// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule-word helper functions and FSM encoding.
// Imported by the message-schedule datapath blocks.
package sha256_pkg;

   localparam int SHA256_WORD_W = 32;
   localparam int SHA256_ROUNDS = 64;

   localparam int S0_ROT_A = 7;
   localparam int S0_ROT_B = 18;
   localparam int S0_SHR   = 3;
   localparam int S1_ROT_A = 17;
   localparam int S1_ROT_B = 19;
   localparam int S1_SHR   = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [SHA256_WORD_W-1:0] rotr(input logic [SHA256_WORD_W-1:0] x,
                                                     input int                        n);
      return (x >> n) | (x << (SHA256_WORD_W - n));
   endfunction

   function automatic logic [SHA256_WORD_W-1:0] small_sigma0(input logic [SHA256_WORD_W-1:0] x);
      return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
   endfunction

   function automatic logic [SHA256_WORD_W-1:0] small_sigma1(input logic [SHA256_WORD_W-1:0] x);
      return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
   endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Combinational next schedule word: W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16, wrapping mod 2^32.
// Shared between this window reader and the pipelined schedule stages.
module sha256_w_next
   import sha256_pkg::*;
(
   input  logic [SHA256_WORD_W-1:0] w_tm16,
   input  logic [SHA256_WORD_W-1:0] w_tm15,
   input  logic [SHA256_WORD_W-1:0] w_tm7,
   input  logic [SHA256_WORD_W-1:0] w_tm2,
   output logic [SHA256_WORD_W-1:0] w_new
);

   assign w_new = small_sigma1(w_tm2) + w_tm7 + small_sigma0(w_tm15) + w_tm16;

endmodule

// File: rtl/sha256_w_stream_reader.sv
// Loads one padded 512-bit block into a 16-word sliding window and streams W_0..W_63
// with ready/valid backpressure, deriving each new word as the window slides.
module sha256_w_stream_reader
   import sha256_pkg::*;
#(
   parameter int WORD_W = SHA256_WORD_W,
   parameter int ROUNDS = SHA256_ROUNDS
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   input  logic [16*WORD_W-1:0] blk_in,
   input  logic                 flush,
   output logic                 w_valid,
   input  logic                 w_ready,
   output logic [WORD_W-1:0]    w_out,
   output logic [5:0]           w_idx,
   output logic                 w_last
);

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   state_e            state_q;
   logic [5:0]        cnt_q;
   logic [5:0]        cnt_d;
   logic [WORD_W-1:0] window_q [16];
   logic [WORD_W-1:0] w_new;
   logic              blk_ready_q;
   logic              w_valid_q;
   logic              w_last_q;

   // window_q[0] is always the word on display, so the taps sit at fixed offsets.
   sha256_w_next u_w_next (
      .w_tm16 (window_q[0]),
      .w_tm15 (window_q[1]),
      .w_tm7  (window_q[9]),
      .w_tm2  (window_q[14]),
      .w_new  (w_new)
   );

   assign cnt_d = cnt_q + 6'd1;

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values; a blocking shift would ripple one word through the whole window.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         blk_ready_q <= 1'b1;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         // NOTE: the window is a register array, not a RAM, so it can take the async reset.
         for (int i = 0; i < 16; i++) window_q[i] <= '0;
      end else if (flush) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         blk_ready_q <= 1'b1;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (blk_valid) begin
                  for (int i = 0; i < 16; i++)
                     window_q[i] <= blk_in[(16*WORD_W-1) - i*WORD_W -: WORD_W];
                  cnt_q       <= '0;
                  state_q     <= RUN;
                  blk_ready_q <= 1'b0;
                  w_valid_q   <= 1'b1;
                  w_last_q    <= 1'b0;
               end
            end
            RUN: begin
               if (w_ready) begin
                  for (int i = 0; i < 15; i++) window_q[i] <= window_q[i+1];
                  window_q[15] <= w_new;
                  if (cnt_q == LAST_IDX) begin
                     state_q     <= IDLE;
                     cnt_q       <= '0;
                     blk_ready_q <= 1'b1;
                     w_valid_q   <= 1'b0;
                     w_last_q    <= 1'b0;
                  end else begin
                     cnt_q    <= cnt_d;
                     w_last_q <= (cnt_d == LAST_IDX);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign blk_ready = blk_ready_q;
   assign w_valid   = w_valid_q;
   assign w_last    = w_last_q;
   assign w_out     = window_q[0];
   assign w_idx     = cnt_q;

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Scoreboarded bench: the stimulus pushes the expected 64-word schedule per accepted block,
// an independent monitor compares every presented word against the queue head.
module tb_sha256_w_stream_reader;

   logic         CLK = 1'b0;
   logic         RST;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_in;
   logic         flush;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_out;
   logic [5:0]   w_idx;
   logic         w_last;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] w;
      int          idx;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] sched [64];

   sha256_w_stream_reader dut (
      .CLK       (CLK),
      .RST       (RST),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_in    (blk_in),
      .flush     (flush),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_out     (w_out),
      .w_idx     (w_idx),
      .w_last    (w_last)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference schedule, straight from the recurrence over the full 64-entry array.
   function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] m_s0(input logic [31:0] x);
      return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] m_s1(input logic [31:0] x);
      return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_sched(input logic [511:0] b);
      for (int t = 0; t < 16; t++) sched[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         sched[t] = m_s1(sched[t-2]) + sched[t-7] + m_s0(sched[t-15]) + sched[t-16];
   endtask

   task automatic push_block(input logic [511:0] b);
      build_sched(b);
      for (int t = 0; t < 64; t++) exp_q.push_back('{w: sched[t], idx: t});
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // Monitor: every presented word must match the queue head; a beat retires it.
   always @(negedge CLK) begin
      if (RST && w_valid && !flush) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: actual idx=%0d w=%h required=no word", w_idx, w_out);
         end else begin
            check("w_out", w_out, exp_q[0].w);
            check("w_idx", 32'(w_idx), 32'(exp_q[0].idx));
            check("w_last", 32'(w_last), 32'(exp_q[0].idx == 63));
            check("blk_ready_in_run", 32'(blk_ready), 32'd0);
            if (w_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Offer a block and wait for the handshake; returns at posedge+1 of the cycle after it.
   task automatic offer(input logic [511:0] b);
      int g = 0;
      blk_in    = b;
      blk_valid = 1'b1;
      push_block(b);
      @(negedge CLK);
      while (!blk_ready && g < 100) begin
         @(negedge CLK);
         g++;
      end
      check("blk_ready_accept", 32'(blk_ready), 32'd1);
      @(posedge CLK);
      #1;
      blk_valid = 1'b0;
      blk_in    = rand_block();
   endtask

   // Drive w_ready until stop_at beats have been taken; random mode stalls 5 cycles at t=15,16,63.
   task automatic stream(input bit rand_ready, input int stop_at);
      int t = 0;
      int guard = 0;
      int stall [64];
      for (int i = 0; i < 64; i++) stall[i] = 0;
      while (t < stop_at && guard < 2000) begin
         if (rand_ready && (t == 15 || t == 16 || t == 63) && stall[t] < 5) begin
            w_ready = 1'b0;
            stall[t]++;
         end else if (rand_ready) begin
            w_ready = ($urandom_range(0, 2) != 0);
         end else begin
            w_ready = 1'b1;
         end
         @(negedge CLK);
         check("w_valid_held", 32'(w_valid), 32'd1);
         @(posedge CLK);
         if (w_ready) t++;
         #1;
         guard++;
      end
      if (t < stop_at) begin
         n_checks++;
         n_errors++;
         $display("FAIL stream_timeout: actual beats=%0d required=%0d", t, stop_at);
      end
   endtask

   task automatic idle_check(input string name);
      w_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check({name, "_w_valid"}, 32'(w_valid), 32'd0);
      check({name, "_blk_ready"}, 32'(blk_ready), 32'd1);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [511:0] abc;
      logic [511:0] ones;
      logic [511:0] b2;

      abc       = '0;
      abc[511:480] = 32'h6162_6380;
      abc[31:0]    = 32'h0000_0018;
      ones      = '1;

      RST       = 1'b1;
      blk_valid = 1'b0;
      blk_in    = '0;
      flush     = 1'b0;
      w_ready   = 1'b0;
      #2 RST = 1'b0;
      #1;
      check("rst_blk_ready", 32'(blk_ready), 32'd1);
      check("rst_w_valid", 32'(w_valid), 32'd0);
      check("rst_w_out", w_out, 32'd0);
      check("rst_w_idx", 32'(w_idx), 32'd0);
      check("rst_w_last", 32'(w_last), 32'd0);
      #19 RST = 1'b1;
      @(posedge CLK);
      #1;

      build_sched(abc);
      check("model_abc_w16", sched[16], 32'h6162_6380);
      check("model_abc_w17", sched[17], 32'h000F_0000);
      check("model_abc_w18", sched[18], 32'h7DA8_6405);

      // abc block, w_ready tied high, then with random backpressure
      offer(abc);
      stream(1'b0, 64);
      idle_check("abc_end");
      offer(abc);
      stream(1'b1, 64);
      idle_check("abc_stall_end");

      // back-to-back: second block held on blk_valid during the first stream
      offer(rand_block());
      b2        = rand_block();
      blk_in    = b2;
      blk_valid = 1'b1;
      push_block(b2);
      stream(1'b0, 64);
      w_ready = 1'b0;
      @(negedge CLK);
      check("b2b_slot_blk_ready", 32'(blk_ready), 32'd1);
      check("b2b_slot_w_valid", 32'(w_valid), 32'd0);
      @(posedge CLK);
      #1;
      blk_valid = 1'b0;
      stream(1'b0, 64);
      idle_check("b2b_end");

      // flush at t=30 together with a beat
      offer(abc);
      stream(1'b0, 30);
      exp_q.delete();
      flush   = 1'b1;
      w_ready = 1'b1;
      @(posedge CLK);
      #1;
      flush   = 1'b0;
      w_ready = 1'b0;
      @(negedge CLK);
      check("flush_w_valid", 32'(w_valid), 32'd0);
      check("flush_blk_ready", 32'(blk_ready), 32'd1);
      @(posedge CLK);
      #1;
      // flush beats a simultaneous block handshake
      blk_valid = 1'b1;
      flush     = 1'b1;
      @(posedge CLK);
      #1;
      blk_valid = 1'b0;
      flush     = 1'b0;
      @(negedge CLK);
      check("flush_blocks_accept", 32'(w_valid), 32'd0);
      @(posedge CLK);
      #1;
      offer(rand_block());
      stream(1'b1, 64);
      idle_check("post_flush_end");

      // asynchronous reset mid-stream at t=40
      offer(abc);
      stream(1'b0, 40);
      w_ready = 1'b0;
      exp_q.delete();
      #1 RST = 1'b0;
      #1;
      check("async_rst_w_valid", 32'(w_valid), 32'd0);
      check("async_rst_w_out", w_out, 32'd0);
      check("async_rst_blk_ready", 32'(blk_ready), 32'd1);
      check("async_rst_w_idx", 32'(w_idx), 32'd0);
      #4 RST = 1'b1;
      @(posedge CLK);
      #1;
      offer(rand_block());
      stream(1'b1, 64);
      idle_check("post_rst_end");

      // all-ones block exercises wrap-around
      build_sched(ones);
      check("model_ones_w16", sched[16], 32'h203F_FFFC);
      offer(ones);
      stream(1'b1, 64);
      idle_check("ones_end");

      for (int k = 0; k < 2; k++) begin
         offer(rand_block());
         stream(1'b1, 64);
         idle_check("rand_end");
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sha256_w_stream_reader.md
Name: sha256_w_stream_reader

Overview:
- Consumer end of the SHA-256 message-schedule window.
- Accepts one padded 512-bit message block per handshake and keeps a 16-word sliding window in registers.
- Streams W_0..W_63 one word per accepted beat to the round/compression datapath, with ready/valid backpressure.
- Sits between the block buffer (upstream) and the round engine (downstream), replacing per-stage schedule registers when area matters more than throughput.

Parameters:
- WORD_W, 32, schedule word width (fixed for SHA-256; any other value is illegal)
- ROUNDS, 64, number of W words emitted per block

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous active-low reset
- blk_valid  input  1  upstream block available
- blk_ready  output  1  block accepted when blk_valid && blk_ready
- blk_in  input  512  padded message block; W_0 = blk_in[511:480], W_15 = blk_in[31:0]
- flush  input  1  synchronous abort; discards the current block
- w_valid  output  1  w_out holds a valid schedule word
- w_ready  input  1  downstream accepts the word
- w_out  output  32  current schedule word W_t
- w_idx  output  6  index t of w_out
- w_last  output  1  high with w_valid when t = 63

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE; window cleared to 0; counter = 0.
  - blk_ready = 1; w_valid = 0; w_out = 0; w_idx = 0; w_last = 0.
- States: IDLE, RUN.
- IDLE:
  - blk_ready = 1, w_valid = 0.
  - On blk_valid: load window[0..15] = W_0..W_15 from blk_in, set counter = 0, go to RUN.
- RUN:
  - blk_ready = 0, w_valid = 1.
  - w_out = window[0], w_idx = counter, w_last = (counter == 63).
- Beat: w_valid && w_ready.
  - On each beat: window shifts down one word (window[i] <= window[i+1]); window[15] <= W_new; counter increments.
  - W_new = s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32.
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - W_new is computed and loaded for every beat, including t >= 48; words beyond W_63 are never presented.
- Beat with counter = 63: go to IDLE; counter returns to 0.
- Backpressure: while w_valid && !w_ready, window, counter, w_out and w_idx hold stable. w_valid never drops before the beat.
- Latency:
  - Block handshake in cycle N gives W_0 on w_out in cycle N+1.
  - With w_ready tied high, W_t appears in cycle N+1+t.
  - Throughput is 65 cycles per block (64 beats plus 1 IDLE accept cycle).
- No accept during RUN: blk_ready stays 0; upstream holds blk_valid and blk_in.
- flush:
  - In any state, next cycle is state = IDLE, counter = 0, w_valid = 0.
  - flush wins over a simultaneous beat or block handshake; that block is not accepted.
  - Window contents after flush are don't-care.
- Asynchronous reset mid-RUN: outputs return to reset values immediately; the partial stream is abandoned and there is no resume.
- blk_in is sampled only on a handshake; changes at other times are ignored.
- All additions wrap modulo 2^32; no carry is kept.

Decomposition:
- Shared package sha256_pkg:
  - SHA256_WORD_W = 32, SHA256_ROUNDS = 64
  - rotate/shift amounts: 7, 18, 3 for s0; 17, 19, 10 for s1
  - state encoding: IDLE = 0, RUN = 1
- One combinational sub-module, sha256_w_next:
  - inputs: w_tm16, w_tm15, w_tm7, w_tm2
  - output: W_new
  - The same sub-module is reusable by the pipelined schedule stages.

Test Plan:
- Reset, then the "abc" padded block (W_0 = 0x61626380, W_1..W_14 = 0, W_15 = 0x00000018), w_ready = 1 -> W_0 = 0x61626380 in cycle N+1; W_16 = 0x61626380, W_17 = 0x000F0000, W_18 = 0x7DA86405; all 64 words match the golden model; w_last only at w_idx = 63.
- Same block with w_ready toggled randomly (including 5-cycle stalls at t = 15, 16 and 63) -> word sequence identical to the previous case; w_out and w_idx stable during stalls.
- Back-to-back blocks with blk_valid held high -> second block accepted exactly one cycle after the t = 63 beat; blk_ready = 0 throughout RUN.
- flush asserted at t = 30 together with w_ready -> w_valid = 0 next cycle; blk_ready = 1; next block streams from W_0 correctly.
- RST pulsed low mid-cycle at t = 40 -> w_valid and w_out go to 0 without waiting for a clock edge; after release, a new block streams correctly.
- All-ones block (0xFFFFFFFF x 16) -> W_16 = s1(0xFFFFFFFF) + 0xFFFFFFFF + s0(0xFFFFFFFF) + 0xFFFFFFFF mod 2^32, matching the model (checks wrap-around).
